// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: PC-select encodings and hazard FSM state encodings.
package pipe_ctrl_pkg;
  localparam logic [1:0] PC_SEL_SEQ      = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP     = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH   = 2'b10;
  localparam logic [1:0] PC_SEL_REDIRECT = 2'b11;
  typedef enum logic [1:0] {S_RUN, S_STALL_LU, S_MEM_WAIT, S_REDIRECT} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu
);
  assign lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC/pipeline-register stall and flush sequencing with branch replay after memory waits.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic [31:0]      exmem_target,
  input  logic             mem_busy,
  output logic             pcwrite,
  output logic [1:0]       pc_sel,
  output logic [31:0]      redirect_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_d;
  logic        lu, taken, stall_inc, flush_inc;
  assign taken = exmem_branch & exmem_zero;
  load_use_detect #(.REG_W(REG_W)) u_lu (
    .ex_memread(ex_memread),
    .ex_rt(ex_rt),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .lu(lu)
  );
  always_comb begin
    pcwrite = 1'b1;
    if_id_write = 1'b1;
    pc_sel = PC_SEL_SEQ;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_flush = 1'b0;
    state_d = state_q;
    pend_d = pend_q;
    tgt_d = redirect_target;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!reset) begin
      pcwrite = 1'b0;
      if_id_write = 1'b0;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (state_q == S_REDIRECT) begin
      if (mem_busy) begin
        pcwrite = 1'b0;
        if_id_write = 1'b0;
        stall_inc = 1'b1;
      end else begin
        pc_sel = PC_SEL_REDIRECT;
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
        flush_inc = 1'b1;
        pend_d = 1'b0;
        state_d = S_RUN;
      end
    end else if (state_q == S_MEM_WAIT && (mem_busy || pend_q)) begin
      // A branch seen during the wait is replayed once memory releases.
      pcwrite = 1'b0;
      if_id_write = 1'b0;
      stall_inc = 1'b1;
      if (mem_busy) begin
        pend_d = pend_q | taken;
        tgt_d = taken ? exmem_target : redirect_target;
      end else begin
        state_d = S_REDIRECT;
      end
    end else begin
      state_d = S_RUN;
      if (mem_busy) begin
        pcwrite = 1'b0;
        if_id_write = 1'b0;
        pend_d = taken;
        tgt_d = exmem_target;
        state_d = S_MEM_WAIT;
        stall_inc = 1'b1;
      end else if (taken) begin
        pc_sel = PC_SEL_BRANCH;
        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
        flush_inc = 1'b1;
      end else if (lu && state_q != S_STALL_LU) begin
        pcwrite = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        state_d = S_STALL_LU;
        stall_inc = 1'b1;
      end else if (id_jump) begin
        pc_sel = PC_SEL_JUMP;
        if_id_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      pend_q <= 1'b0;
      redirect_target <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      redirect_target <= tgt_d;
      stall_cnt <= (stall_inc && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
      flush_cnt <= (flush_inc && flush_cnt != '1) ? flush_cnt + CNT_W'(1) : flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with queued expectations checked by a negedge monitor.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_jump, ex_memread, exmem_branch, exmem_zero, mem_busy;
  logic [31:0] exmem_target;
  logic        pcwrite, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_target;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pcwrite, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
  logic [1:0]  s_pc_sel;
  logic [31:0] s_redirect_target;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] tgt;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [1:0]  small_stall;
  } exp_t;
  exp_t exp_q[$];
  localparam logic [6:0] NORM = 7'b1_00_1_000;
  localparam logic [6:0] FRZ  = 7'b0_00_0_000;
  localparam logic [6:0] LUS  = 7'b0_00_0_010;
  localparam logic [6:0] BR   = 7'b1_10_1_111;
  localparam logic [6:0] JMP  = 7'b1_01_1_100;
  localparam logic [6:0] RDR  = 7'b1_11_1_111;
  localparam logic [6:0] RST  = 7'b0_00_0_111;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .exmem_branch(exmem_branch),
    .exmem_zero(exmem_zero), .exmem_target(exmem_target), .mem_busy(mem_busy),
    .pcwrite(pcwrite), .pc_sel(pc_sel), .redirect_target(redirect_target),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .exmem_branch(exmem_branch),
    .exmem_zero(exmem_zero), .exmem_target(exmem_target), .mem_busy(mem_busy),
    .pcwrite(s_pcwrite), .pc_sel(s_pc_sel), .redirect_target(s_redirect_target),
    .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic exp_t e = exp_q.pop_front();
      automatic logic [6:0] ctl = {pcwrite, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush};
      n_checks += 5;
      if (ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl t=%0t got %b want %b", $time, ctl, e.ctl);
      end
      if (redirect_target !== e.tgt) begin
        n_fail++;
        $display("FAIL redirect_target t=%0t got %h want %h", $time, redirect_target, e.tgt);
      end
      if (stall_cnt !== e.stall) begin
        n_fail++;
        $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, stall_cnt, e.stall);
      end
      if (flush_cnt !== e.flush) begin
        n_fail++;
        $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, flush_cnt, e.flush);
      end
      if (s_stall_cnt !== e.small_stall) begin
        n_fail++;
        $display("FAIL small_stall_cnt t=%0t got %0d want %0d", $time, s_stall_cnt, e.small_stall);
      end
    end
  end
  task automatic step(input logic rn, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic jmp, input logic mrd, input logic [4:0] ert, input logic br,
                      input logic zr, input logic [31:0] tg, input logic busy,
                      input logic [6:0] ectl, input logic [31:0] etgt, input int es, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rn; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jump = jmp; ex_memread = mrd;
    ex_rt = ert; exmem_branch = br; exmem_zero = zr; exmem_target = tg; mem_busy = busy;
    e.ctl = ectl;
    e.tgt = etgt;
    e.stall = 16'(es);
    e.flush = 16'(ef);
    e.small_stall = (es > 3) ? 2'd3 : 2'(es);
    exp_q.push_back(e);
  endtask
  task automatic idle(input logic [6:0] ectl, input logic [31:0] etgt, input int es, input int ef);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ectl, etgt, es, ef);
  endtask
  task automatic busy(input logic br, input logic [31:0] tg, input logic [31:0] etgt, input int es, input int ef);
    step(1, 0, 0, 0, 0, 0, 0, br, br, tg, 1, FRZ, etgt, es, ef);
  endtask
  initial begin
    reset = 1'b0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0; ex_memread = 0;
    ex_rt = 0; exmem_branch = 0; exmem_zero = 0; exmem_target = 0; mem_busy = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 0);
    idle(NORM, 0, 0, 0);
    step(1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0, LUS, 0, 0, 0);
    step(1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0, NORM, 0, 1, 0);
    idle(NORM, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
    step(1, 1, 3, 0, 0, 1, 3, 0, 0, 0, 0, NORM, 0, 1, 0);
    step(1, 1, 3, 1, 0, 1, 3, 0, 0, 0, 0, LUS, 0, 1, 0);
    idle(NORM, 0, 2, 0);
    step(1, 0, 0, 0, 1, 0, 0, 1, 1, 32'h40, 0, BR, 0, 2, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, JMP, 0, 2, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, NORM, 0, 2, 1);
    busy(1, 32'h80, 0, 2, 1);
    busy(0, 0, 32'h80, 3, 1);
    busy(0, 0, 32'h80, 4, 1);
    idle(FRZ, 32'h80, 5, 1);
    idle(RDR, 32'h80, 6, 1);
    idle(NORM, 32'h80, 6, 2);
    busy(1, 32'hC0, 32'h80, 6, 2);
    busy(0, 0, 32'hC0, 7, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0, 0, 0);
    idle(NORM, 0, 0, 0);
    idle(NORM, 0, 0, 0);
    for (int i = 0; i < 5; i++) busy(0, 0, 0, i, 0);
    idle(NORM, 0, 5, 0);
    idle(NORM, 0, 5, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
